// File: rtl/arcade_input_mapper.sv
// Arcade input mapper: merges PS/2 keyboard keys and per-player joystick words
// into registered per-player controls, start buttons and a conditioned coin
// pulse, with optional autofire gating of fire button A.
module arcade_input_mapper #(
   parameter int NPLAYERS     = 2,
   parameter int COIN_PULSE   = 2000000,
   parameter int AUTOFIRE_DIV = 1333333
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic [10:0]           ps2_key,
   input  logic [16*NPLAYERS-1:0] joy_in,
   input  logic [NPLAYERS-1:0]   autofire_en,
   output logic [6*NPLAYERS-1:0] ctrl,
   output logic [1:0]            start,
   output logic                  coin,
   output logic                  key_evt
);

   localparam int CNT_W = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
   localparam int AF_W  = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COIN_PULSE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [AF_W-1:0]  AF_LAST  = AF_W'(AUTOFIRE_DIV - 1);
   localparam logic [AF_W-1:0]  AF_ONE   = AF_W'(1);
   localparam logic             P1_EN    = (NPLAYERS >= 2) ? 1'b1 : 1'b0;

   // Key register layout: player 0 in ctrl bit order, player 1 likewise, then globals.
   localparam int K_P0_R   = 0;
   localparam int K_P0_L   = 1;
   localparam int K_P0_D   = 2;
   localparam int K_P0_U   = 3;
   localparam int K_P0_A   = 4;
   localparam int K_P0_B   = 5;
   localparam int K_P1_R   = 6;
   localparam int K_P1_L   = 7;
   localparam int K_P1_D   = 8;
   localparam int K_P1_U   = 9;
   localparam int K_P1_A   = 10;
   localparam int K_P1_B   = 11;
   localparam int K_START1 = 12;
   localparam int K_START2 = 13;
   localparam int K_COIN   = 14;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PULSE    = 2'd1,
      ST_WAIT_REL = 2'd2
   } coin_state_t;

   logic                  tog_r;
   logic                  primed_r;
   logic                  key_evt_r;
   logic [14:0]           keys_r;
   logic [14:0]           key_sel_s;
   logic [6*NPLAYERS-1:0] ctrl_r;
   logic [6*NPLAYERS-1:0] ctrl_next_s;
   logic [1:0]            start_r;
   logic [1:0]            start_next_s;
   logic [5:0]            raw_s;
   logic                  coin_src_s;
   logic                  joy_unused_s;
   logic [AF_W-1:0]       af_cnt_r;
   logic                  phase_r;
   coin_state_t           state_r;
   logic [CNT_W-1:0]      cnt_r;

   // Decode {extended, scan code} into the key register it controls.
   always_comb begin
      key_sel_s = 15'd0;
      case ({ps2_key[8], ps2_key[7:0]})
         9'h175:  key_sel_s[K_P0_U]   = 1'b1;
         9'h172:  key_sel_s[K_P0_D]   = 1'b1;
         9'h16B:  key_sel_s[K_P0_L]   = 1'b1;
         9'h174:  key_sel_s[K_P0_R]   = 1'b1;
         9'h014:  key_sel_s[K_P0_A]   = 1'b1;
         9'h011:  key_sel_s[K_P0_B]   = 1'b1;
         9'h02D:  key_sel_s[K_P1_U]   = P1_EN;
         9'h02B:  key_sel_s[K_P1_D]   = P1_EN;
         9'h023:  key_sel_s[K_P1_L]   = P1_EN;
         9'h034:  key_sel_s[K_P1_R]   = P1_EN;
         9'h01C:  key_sel_s[K_P1_A]   = P1_EN;
         9'h01B:  key_sel_s[K_P1_B]   = P1_EN;
         9'h005,
         9'h016:  key_sel_s[K_START1] = 1'b1;
         9'h006,
         9'h01E:  key_sel_s[K_START2] = 1'b1;
         9'h076,
         9'h02E,
         9'h036:  key_sel_s[K_COIN]   = 1'b1;
         default: key_sel_s = 15'd0;
      endcase
   end

   // Detect PS/2 toggle events (skipping the first post-reset clock) and update key state.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         tog_r     <= 1'b0;
         primed_r  <= 1'b0;
         key_evt_r <= 1'b0;
         keys_r    <= 15'd0;
      end else begin
         tog_r    <= ps2_key[10];
         primed_r <= 1'b1;
         if (primed_r && (ps2_key[10] != tog_r)) begin
            key_evt_r <= 1'b1;
            keys_r    <= (keys_r & ~key_sel_s) | (key_sel_s & {15{ps2_key[9]}});
         end else begin
            key_evt_r <= 1'b0;
         end
      end
   end

   // Merge key registers with joystick words; apply autofire gating to fire A.
   always_comb begin
      ctrl_next_s  = '0;
      start_next_s = {keys_r[K_START2], keys_r[K_START1]};
      coin_src_s   = keys_r[K_COIN];
      raw_s        = 6'd0;
      joy_unused_s = 1'b0;
      for (int i = 0; i < NPLAYERS; i++) begin
         raw_s = joy_in[16*i +: 6] |
                 ((i == 0) ? keys_r[5:0] : ((i == 1) ? keys_r[11:6] : 6'd0));
         raw_s[4] = raw_s[4] & (~autofire_en[i] | phase_r);
         ctrl_next_s[6*i +: 6] = raw_s;
         start_next_s[0] = start_next_s[0] | joy_in[16*i + 6];
         start_next_s[1] = start_next_s[1] | joy_in[16*i + 7];
         coin_src_s      = coin_src_s | joy_in[16*i + 8];
         joy_unused_s    = joy_unused_s ^ (^joy_in[16*i + 9 +: 7]);
      end
   end

   // Register the control and start outputs.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         ctrl_r  <= '0;
         start_r <= 2'd0;
      end else begin
         ctrl_r  <= ctrl_next_s;
         start_r <= start_next_s;
      end
   end

   // Free-running autofire divider; phase flips every AUTOFIRE_DIV cycles.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         af_cnt_r <= '0;
         phase_r  <= 1'b1;
      end else if (af_cnt_r == AF_LAST) begin
         af_cnt_r <= '0;
         phase_r  <= ~phase_r;
      end else begin
         af_cnt_r <= af_cnt_r + AF_ONE;
      end
   end

   // Coin conditioner: one fixed-length pulse per source assertion, held source must release.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (coin_src_s) begin
                  state_r <= ST_PULSE;
                  cnt_r   <= CNT_LAST;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_PULSE: begin
               if (cnt_r == '0) begin
                  state_r <= coin_src_s ? ST_WAIT_REL : ST_IDLE;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_WAIT_REL: begin
               if (!coin_src_s) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_WAIT_REL;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   assign ctrl    = ctrl_r;
   assign start   = start_r;
   assign key_evt = key_evt_r;
   assign coin    = (state_r == ST_PULSE);

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper: a two-player instance with short
// coin/autofire periods plus a one-player instance for the single-player cases.
module tb_arcade_input_mapper;

   logic        clk = 1'b0;
   logic        rst;
   logic        rst1;
   logic [10:0] ps2_key;
   logic [31:0] joy;
   logic [1:0]  af_en;
   logic [11:0] ctrl;
   logic [1:0]  start;
   logic        coin;
   logic        key_evt;
   logic [15:0] joy1;
   logic [0:0]  af_en1;
   logic [5:0]  ctrl1;
   logic [1:0]  start1;
   logic        coin1;
   logic        key_evt1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] joy;
      logic [11:0] ctrl;
      logic [1:0]  start;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   arcade_input_mapper #(.NPLAYERS(2), .COIN_PULSE(4), .AUTOFIRE_DIV(3)) dut (
      .clk_sys(clk), .reset(rst), .ps2_key(ps2_key), .joy_in(joy),
      .autofire_en(af_en), .ctrl(ctrl), .start(start), .coin(coin), .key_evt(key_evt)
   );

   arcade_input_mapper #(.NPLAYERS(1), .COIN_PULSE(4), .AUTOFIRE_DIV(3)) dut1 (
      .clk_sys(clk), .reset(rst1), .ps2_key(ps2_key), .joy_in(joy1),
      .autofire_en(af_en1), .ctrl(ctrl1), .start(start1), .coin(coin1), .key_evt(key_evt1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Toggle the PS/2 event bit with a new key, verify the one-cycle strobe on both DUTs.
   task automatic ps2_send(input logic pr, input logic ex, input logic [7:0] code);
      @(negedge clk);
      ps2_key = {~ps2_key[10], pr, ex, code};
      @(posedge clk); #1;
      check("key_evt_hi", 32'(key_evt), 32'd1);
      check("key_evt1_hi", 32'(key_evt1), 32'd1);
      @(posedge clk); #1;
      check("key_evt_lo", 32'(key_evt), 32'd0);
   endtask

   initial begin
      vecs[0] = '{32'h0000_0000, 12'h000, 2'b00};
      vecs[1] = '{32'h0000_0001, 12'h001, 2'b00};
      vecs[2] = '{32'h0000_000A, 12'h00A, 2'b00};
      vecs[3] = '{32'h0000_0030, 12'h030, 2'b00};
      vecs[4] = '{32'h0004_0000, 12'h100, 2'b00};
      vecs[5] = '{32'h003F_0000, 12'hFC0, 2'b00};
      vecs[6] = '{32'h0000_0040, 12'h000, 2'b01};
      vecs[7] = '{32'h0080_0000, 12'h000, 2'b10};
      vecs[8] = '{32'h0000_00C0, 12'h000, 2'b11};
      vecs[9] = '{32'hFE00_FE00, 12'h000, 2'b00};

      rst = 1'b1; rst1 = 1'b1;
      ps2_key = 11'h400;
      joy = 32'd0; af_en = 2'b00; joy1 = 16'd0; af_en1 = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctrl", 32'(ctrl), 32'd0);
      check("rst_start", 32'(start), 32'd0);
      check("rst_coin", 32'(coin), 32'd0);
      check("rst_key_evt", 32'(key_evt), 32'd0);
      check("rst1_outs", 32'({ctrl1, start1, coin1, key_evt1}), 32'd0);

      // Toggle bit high through reset: the first clock only primes, no event
      @(negedge clk);
      rst = 1'b0; rst1 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         check("prime_key_evt", 32'(key_evt), 32'd0);
         check("prime_outs", 32'({ctrl, start, coin}), 32'd0);
      end

      // Joystick vectors: one clock latency to ctrl/start
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         joy = vecs[i].joy;
         @(posedge clk); #1;
         check($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].ctrl));
         check($sformatf("vec%0d_start", i), 32'(start), 32'(vecs[i].start));
      end
      @(negedge clk);
      joy = 32'd0;
      @(posedge clk); #1;

      // PS/2 key mapping
      ps2_send(1'b1, 1'b1, 8'h75);
      check("ext75_up", 32'(ctrl), 32'h008);
      ps2_send(1'b0, 1'b1, 8'h75);
      check("ext75_rel", 32'(ctrl), 32'h000);
      ps2_send(1'b1, 1'b0, 8'h75);
      check("nonext75_ignored", 32'(ctrl), 32'h000);
      ps2_send(1'b0, 1'b0, 8'h75);
      ps2_send(1'b1, 1'b1, 8'h6B);
      check("ext6B_left", 32'(ctrl), 32'h002);
      ps2_send(1'b0, 1'b1, 8'h6B);
      ps2_send(1'b1, 1'b0, 8'h14);
      check("k14_p0_a", 32'(ctrl), 32'h010);
      ps2_send(1'b0, 1'b0, 8'h14);
      ps2_send(1'b1, 1'b0, 8'h1C);
      check("k1C_p1_a", 32'(ctrl), 32'h400);
      check("np1_k1C_ctrl", 32'(ctrl1), 32'h00);
      ps2_send(1'b0, 1'b0, 8'h1C);
      ps2_send(1'b1, 1'b0, 8'h05);
      check("k05_start1", 32'(start), 32'h1);
      ps2_send(1'b0, 1'b0, 8'h05);
      ps2_send(1'b1, 1'b0, 8'h1E);
      check("k1E_start2", 32'(start), 32'h2);
      ps2_send(1'b0, 1'b0, 8'h1E);
      ps2_send(1'b1, 1'b0, 8'h99);
      check("unmapped", 32'({ctrl, start, coin}), 32'd0);

      // Held joystick coin: exactly one 4-cycle pulse starting one clock after rise
      @(negedge clk);
      joy = 32'h0000_0100;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         check($sformatf("coin_hold_c%0d", k), 32'(coin), 32'((k <= 4) ? 1 : 0));
      end
      @(negedge clk);
      joy = 32'd0;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         check("coin_released", 32'(coin), 32'd0);
      end
      @(negedge clk);
      joy = 32'h0000_0100;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         check($sformatf("coin_second_c%0d", k), 32'(coin), 32'((k <= 4) ? 1 : 0));
      end
      @(negedge clk);
      joy = 32'd0;
      repeat (2) @(posedge clk);

      // Coin key 2E with a joystick coin pulse inside the pulse: no extension
      @(negedge clk);
      ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h2E};
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         check($sformatf("coin_key_c%0d", k), 32'(coin), 32'((k >= 2 && k <= 5) ? 1 : 0));
         if (k == 1) check("coin_key_evt", 32'(key_evt), 32'd1);
         if (k == 2) begin @(negedge clk); joy = 32'h0000_0100; end
         if (k == 3) begin @(negedge clk); joy = 32'd0; end
      end
      ps2_send(1'b0, 1'b0, 8'h2E);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         check("coin_key_released", 32'(coin), 32'd0);
      end

      // Autofire: player 0 gated (3 high, 3 low, ...), player 1 steady
      @(negedge clk);
      rst = 1'b1;
      joy = 32'h0010_0010;
      af_en = 2'b01;
      @(negedge clk);
      rst = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         check($sformatf("autofire_c%0d", n), 32'(ctrl),
               ((((n - 1) / 3) % 2) == 0) ? 32'h410 : 32'h400);
      end
      @(negedge clk);
      joy = 32'd0; af_en = 2'b00;

      // Single-player instance: asynchronous reset mid pulse, held source restarts
      @(negedge clk);
      joy1 = 16'h0100;
      @(posedge clk); #1;
      check("np1_coin_start", 32'(coin1), 32'd1);
      #2 rst1 = 1'b1;
      #1;
      check("np1_coin_async_rst", 32'(coin1), 32'd0);
      @(negedge clk);
      rst1 = 1'b0;
      @(posedge clk); #1;
      check("np1_coin_restart", 32'(coin1), 32'd1);
      @(negedge clk);
      joy1 = 16'd0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
